// File: rtl/trena_serial_ctrl.sv
// Control unit for the trena: triggers a measurement, then sends an N_CHARS ASCII frame.
// Optional TRENA_TIMEOUT_EN adds the measurement timeout counter and the ERRO state.
module trena_serial_ctrl #(
  parameter int unsigned N_CHARS          = 4,
  parameter int unsigned TIMEOUT_CYCLES   = 50000000,
  parameter int unsigned INTERVALO_CYCLES = 25000000,
  localparam int unsigned SelW = (N_CHARS > 1) ? $clog2(N_CHARS) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            mensurar,
  input  logic            modo_continuo,
  input  logic            pronto_medida,
  input  logic            pronto_transmissao,
  output logic            zera,
  output logic            medir,
  output logic            partida,
  output logic [SelW-1:0] sel_char,
  output logic            pronto,
  output logic            timeout_erro,
  output logic [3:0]      db_estado
);

  localparam int unsigned IntW = (INTERVALO_CYCLES > 2) ? $clog2(INTERVALO_CYCLES) : 1;
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [SelW-1:0] SelLast = SelW'(N_CHARS - 1);
  localparam logic [IntW-1:0] IntLast = IntW'(INTERVALO_CYCLES - 1);

  if (N_CHARS < 1 || N_CHARS > 16) begin : gen_bad_n_chars
    $error("N_CHARS out of range 1..16");
  end
  if (TIMEOUT_CYCLES < 2) begin : gen_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end
  if (INTERVALO_CYCLES < 2) begin : gen_bad_intervalo
    $error("INTERVALO_CYCLES must be at least 2");
  end

  typedef enum logic [3:0] {
    StInicial = 4'b0000,
    StPrepara = 4'b0001,
    StDispara = 4'b0010,
    StMede    = 4'b0011,
    StEnvia   = 4'b0100,
    StAguarda = 4'b0101,
    StFinal   = 4'b0110,
    StErro    = 4'b0111
  } state_e;

  state_e          state_q, state_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [IntW-1:0] int_q, int_d;

`ifdef TRENA_TIMEOUT_EN
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic [TmoW-1:0] tmo_q, tmo_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StInicial;
      sel_q   <= '0;
      int_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      int_q   <= int_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    int_d        = int_q;
`ifdef TRENA_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif
    zera         = 1'b0;
    medir        = 1'b0;
    partida      = 1'b0;
    pronto       = 1'b0;
    timeout_erro = 1'b0;
    db_estado    = state_q;

    unique case (state_q)
      StInicial: begin
        zera = 1'b1;
        if (mensurar) state_d = StPrepara;
      end

      StPrepara: begin
        zera    = 1'b1;
        sel_d   = '0;
`ifdef TRENA_TIMEOUT_EN
        tmo_d   = '0;
`endif
        state_d = StDispara;
      end

      StDispara: begin
        medir   = 1'b1;
        state_d = StMede;
      end

      StMede: begin
        // A ready measurement wins over a timeout landing in the same cycle.
        if (pronto_medida) begin
          state_d = StEnvia;
`ifdef TRENA_TIMEOUT_EN
        end else if (tmo_q == TmoLast) begin
          state_d = StErro;
          int_d   = '0;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
`endif
        end
      end

      StEnvia: begin
        partida = 1'b1;
        state_d = StAguarda;
      end

      StAguarda: begin
        if (pronto_transmissao) begin
          if (sel_q == SelLast) begin
            state_d = StFinal;
            int_d   = '0;
          end else begin
            sel_d   = sel_q + SelW'(1);
            state_d = StEnvia;
          end
        end
      end

      StFinal: begin
        pronto = 1'b1;
        if (mensurar) begin
          state_d = StPrepara;
          int_d   = '0;
        end else if (modo_continuo) begin
          if (int_q == IntLast) begin
            state_d = StPrepara;
            int_d   = '0;
          end else begin
            int_d = int_q + IntW'(1);
          end
        end else begin
          int_d = '0;
        end
      end

`ifdef TRENA_TIMEOUT_EN
      StErro: begin
        timeout_erro = 1'b1;
        if (mensurar) begin
          state_d = StPrepara;
          int_d   = '0;
        end else if (modo_continuo) begin
          if (int_q == IntLast) begin
            state_d = StPrepara;
            int_d   = '0;
          end else begin
            int_d = int_q + IntW'(1);
          end
        end else begin
          int_d = '0;
        end
      end
`endif

      default: begin
        db_estado = 4'b1111;
        state_d   = StInicial;
      end
    endcase
  end

  assign sel_char = sel_q;

endmodule

// File: tb/tb_trena_serial_ctrl.sv
// Directed bench for trena_serial_ctrl (N_CHARS=4, TIMEOUT_CYCLES=20, INTERVALO_CYCLES=10).
module tb_trena_serial_ctrl;

  localparam int unsigned NC   = 4;
  localparam int unsigned TMO  = 20;
  localparam int unsigned INTV = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mensurar = 1'b0;
  logic       modo_continuo = 1'b0;
  logic       pronto_medida = 1'b0;
  logic       pronto_transmissao = 1'b0;
  logic       zera, medir, partida, pronto, timeout_erro;
  logic [1:0] sel_char;
  logic [3:0] db_estado;

  int passed = 0;
  int total = 0;
  int n_medir = 0;
  int n_partida = 0;
  int np;

  trena_serial_ctrl #(
    .N_CHARS         (NC),
    .TIMEOUT_CYCLES  (TMO),
    .INTERVALO_CYCLES(INTV)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .mensurar          (mensurar),
    .modo_continuo     (modo_continuo),
    .pronto_medida     (pronto_medida),
    .pronto_transmissao(pronto_transmissao),
    .zera              (zera),
    .medir             (medir),
    .partida           (partida),
    .sel_char          (sel_char),
    .pronto            (pronto),
    .timeout_erro      (timeout_erro),
    .db_estado         (db_estado)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (medir) n_medir <= n_medir + 1;
    if (partida) n_partida <= n_partida + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered with ENVIA visible and sel_char=0; leaves FINAL visible.
  task automatic send_chars();
    for (int i = 0; i < NC; i++) begin
      chk("envia_state", db_estado, 4'b0100);
      chk("partida_pulse", partida, 1'b1);
      chk("sel_char", sel_char, i);
      step();
      chk("aguarda_state", db_estado, 4'b0101);
      chk("partida_one_cycle", partida, 1'b0);
      step();
      step();
      pronto_transmissao = 1'b1;
      step();
      pronto_transmissao = 1'b0;
    end
    chk("final_state", db_estado, 4'b0110);
    chk("final_pronto", pronto, 1'b1);
    chk("final_sel_char", sel_char, NC - 1);
  endtask

  // Entered with PREPARA visible.
  task automatic run_frame(input int meas_delay);
    chk("prepara_state", db_estado, 4'b0001);
    chk("prepara_zera", zera, 1'b1);
    step();
    chk("dispara_state", db_estado, 4'b0010);
    chk("medir_pulse", medir, 1'b1);
    step();
    chk("mede_state", db_estado, 4'b0011);
    chk("medir_one_cycle", medir, 1'b0);
    repeat (meas_delay - 1) step();
    chk("mede_wait", db_estado, 4'b0011);
    chk("mede_no_error", timeout_erro, 1'b0);
    pronto_medida = 1'b1;
    step();
    pronto_medida = 1'b0;
    send_chars();
  endtask

  initial begin
    repeat (3) step();
    chk("rst_state", db_estado, 4'b0000);
    chk("rst_zera", zera, 1'b1);
    chk("rst_medir", medir, 1'b0);
    chk("rst_partida", partida, 1'b0);
    chk("rst_pronto", pronto, 1'b0);
    chk("rst_timeout", timeout_erro, 1'b0);
    chk("rst_sel", sel_char, 2'd0);
    reset = 1'b0;
    step();
    chk("idle_state", db_estado, 4'b0000);

    // Single frame
    mensurar = 1'b1;
    step();
    mensurar = 1'b0;
    run_frame(5);
    chk("frame1_medir_count", n_medir, 1);
    chk("frame1_partida_count", n_partida, 4);
    repeat (3) step();
    chk("final_hold_state", db_estado, 4'b0110);
    chk("final_hold_sel", sel_char, 2'd3);

    // Continuous mode: three frames with no mensurar
    modo_continuo = 1'b1;
    for (int f = 0; f < 3; f++) begin
      repeat (INTV - 1) step();
      chk("cont_still_final", db_estado, 4'b0110);
      step();
      chk("cont_reprepara", db_estado, 4'b0001);
      run_frame(3);
    end
    modo_continuo = 1'b0;
    chk("cont_medir_count", n_medir, 4);
    chk("cont_partida_count", n_partida, 16);
    step();
    chk("cont_off_final", db_estado, 4'b0110);

`ifdef TRENA_TIMEOUT_EN
    // Timeout into ERRO
    mensurar = 1'b1;
    step();
    mensurar = 1'b0;
    step();
    step();
    chk("tmo_mede_entry", db_estado, 4'b0011);
    repeat (TMO - 1) step();
    chk("tmo_mede_last", db_estado, 4'b0011);
    chk("tmo_not_yet", timeout_erro, 1'b0);
    step();
    chk("tmo_erro_state", db_estado, 4'b0111);
    chk("tmo_erro_flag", timeout_erro, 1'b1);
    chk("tmo_no_pronto", pronto, 1'b0);
    step();
    step();
    chk("tmo_erro_hold", db_estado, 4'b0111);
    mensurar = 1'b1;
    step();
    mensurar = 1'b0;
    chk("erro_exit_state", db_estado, 4'b0001);
    chk("erro_exit_flag", timeout_erro, 1'b0);
    step();
    chk("erro_exit_medir", medir, 1'b1);
    step();
    // Ready arrives in the same cycle the counter reaches its last value
    repeat (TMO - 1) step();
    chk("collide_mede", db_estado, 4'b0011);
    pronto_medida = 1'b1;
    step();
    pronto_medida = 1'b0;
    chk("collide_no_error", timeout_erro, 1'b0);
    send_chars();
`else
    // No timeout: MEDE waits as long as needed
    mensurar = 1'b1;
    step();
    mensurar = 1'b0;
    run_frame(100);
    chk("notmo_flag", timeout_erro, 1'b0);
`endif

    // Reset in AGUARDA with sel_char=2
    mensurar = 1'b1;
    step();
    mensurar = 1'b0;
    step();
    step();
    pronto_medida = 1'b1;
    step();
    pronto_medida = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      pronto_transmissao = 1'b1;
      step();
      pronto_transmissao = 1'b0;
    end
    step();
    chk("mid_aguarda", db_estado, 4'b0101);
    chk("mid_sel", sel_char, 2'd2);
    np = n_partida;
    reset = 1'b1;
    #1;
    chk("async_rst_state", db_estado, 4'b0000);
    step();
    chk("mid_rst_state", db_estado, 4'b0000);
    chk("mid_rst_sel", sel_char, 2'd0);
    chk("mid_rst_zera", zera, 1'b1);
    chk("mid_rst_partida", partida, 1'b0);
    reset = 1'b0;
    pronto_transmissao = 1'b1;
    pronto_medida = 1'b1;
    step();
    pronto_transmissao = 1'b0;
    pronto_medida = 1'b0;
    step();
    chk("late_ptx_state", db_estado, 4'b0000);
    chk("late_ptx_partida", n_partida, np);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
